// File: rtl/noc_run_sequencer.sv
// rtl/noc_run_sequencer.sv - Repeated loader run controller: start pulse, idle-timed runs, PMU dump scan.
module noc_run_sequencer #(
    parameter int NODES          = 16,
    parameter int PMU_ADDR_WIDTH = 5,
    parameter int PMU_DATA_WIDTH = 64,
    parameter int PMU_REGS       = 8,
    parameter int CYC_WIDTH      = 32,
    parameter int REP_WIDTH      = 8,
    localparam int NODE_WIDTH    = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      run_i,
    input  logic [NODES-1:0]          node_mask_i,
    input  logic [REP_WIDTH-1:0]      repeat_i,
    input  logic [CYC_WIDTH-1:0]      timeout_i,
    output logic                      start_o,
    input  logic [NODES-1:0]          idle_i,
    output logic [PMU_ADDR_WIDTH-1:0] pmu_addr_o,
    input  logic [PMU_DATA_WIDTH-1:0] pmu_data_i [NODES],
    output logic                      dump_valid_o,
    input  logic                      dump_ready_i,
    output logic [PMU_DATA_WIDTH-1:0] dump_data_o,
    output logic [NODE_WIDTH-1:0]     dump_node_o,
    output logic [PMU_ADDR_WIDTH-1:0] dump_reg_o,
    output logic [REP_WIDTH-1:0]      dump_iter_o,
    output logic                      dump_last_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [CYC_WIDTH-1:0]      run_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_GUARD, S_RUN, S_SCAN, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [NODES-1:0]          mask_q, mask_d;
    logic [REP_WIDTH-1:0]      reps_q, reps_d, iter_q, iter_d;
    logic [CYC_WIDTH-1:0]      tmo_q, tmo_d, cnt_q, cnt_d, run_cycles_q, run_cycles_d;
    logic                      timed_out_q, timed_out_d;
    logic [NODE_WIDTH-1:0]     node_q, node_d;
    logic [PMU_ADDR_WIDTH-1:0] reg_q, reg_d;
    logic                      present_q, present_d;
    logic [PMU_DATA_WIDTH-1:0] data_q, data_d;

    logic [CYC_WIDTH-1:0]      cnt_inc;
    logic                      all_idle, has_next, last_reg, last_beat;
    logic [NODE_WIDTH-1:0]     first_node, next_node;

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign all_idle  = &(idle_i | ~mask_q);
    assign last_reg  = (reg_q == PMU_ADDR_WIDTH'(PMU_REGS - 1));
    assign last_beat = last_reg && !has_next;

    // Lowest masked node, and the next masked node above the current scan position.
    always_comb begin
        first_node = '0;
        next_node  = node_q;
        has_next   = 1'b0;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_node = NODE_WIDTH'(i);
                if (i > int'(node_q)) begin
                    next_node = NODE_WIDTH'(i);
                    has_next  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        reps_d       = reps_q;
        iter_d       = iter_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        run_cycles_d = run_cycles_q;
        timed_out_d  = timed_out_q;
        node_d       = node_q;
        reg_d        = reg_q;
        present_d    = present_q;
        data_d       = data_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    mask_d      = node_mask_i;
                    reps_d      = (repeat_i == '0) ? REP_WIDTH'(1) : repeat_i;
                    tmo_d       = timeout_i;
                    iter_d      = '0;
                    timed_out_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = (node_mask_i == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                cnt_d = cnt_inc;
                if (cnt_q == CYC_WIDTH'(1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                // Idle wins a tie; >= lets timeouts below the 3-cycle minimum still fire.
                if (all_idle || (tmo_q != '0 && cnt_inc >= tmo_q)) begin
                    timed_out_d  = timed_out_q | ~all_idle;
                    run_cycles_d = cnt_inc;
                    node_d       = first_node;
                    reg_d        = '0;
                    present_d    = 1'b0;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!present_q) begin
                    data_d    = pmu_data_i[node_q];
                    present_d = 1'b1;
                end else if (dump_ready_i) begin
                    present_d = 1'b0;
                    if (last_beat) begin
                        reg_d = '0;
                        if (iter_q != reps_q - 1'b1 && !timed_out_q) begin
                            iter_d  = iter_q + 1'b1;
                            state_d = S_LAUNCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (last_reg) begin
                        reg_d  = '0;
                        node_d = next_node;
                    end else begin
                        reg_d = reg_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            reps_q       <= '0;
            iter_q       <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            run_cycles_q <= '0;
            timed_out_q  <= 1'b0;
            node_q       <= '0;
            reg_q        <= '0;
            present_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            reps_q       <= reps_d;
            iter_q       <= iter_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            run_cycles_q <= run_cycles_d;
            timed_out_q  <= timed_out_d;
            node_q       <= node_d;
            reg_q        <= reg_d;
            present_q    <= present_d;
            data_q       <= data_d;
        end
    end

    assign start_o      = (state_q == S_LAUNCH);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign timeout_o    = timed_out_q;
    assign run_cycles_o = run_cycles_q;
    assign pmu_addr_o   = reg_q;
    assign dump_valid_o = present_q;
    assign dump_data_o  = data_q;
    assign dump_node_o  = node_q;
    assign dump_reg_o   = reg_q;
    assign dump_iter_o  = iter_q;
    assign dump_last_o  = present_q && last_beat;

endmodule

// File: tb/tb_noc_run_sequencer.sv
// tb/tb_noc_run_sequencer.sv - Table-driven run sequences with a dump-beat scoreboard and reset corner cases.
module tb_noc_run_sequencer;

    logic        clk_i, rst_i, run_i;
    logic [15:0] node_mask_i, idle_i;
    logic [7:0]  repeat_i;
    logic [31:0] timeout_i;
    logic        start_o, dump_valid_o, dump_ready_i, dump_last_o, busy_o, done_o, timeout_o;
    logic [4:0]  pmu_addr_o, dump_reg_o;
    logic [63:0] pmu_data_i [16];
    logic [63:0] dump_data_o;
    logic [3:0]  dump_node_o;
    logic [7:0]  dump_iter_o;
    logic [31:0] run_cycles_o;

    noc_run_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .node_mask_i(node_mask_i),
        .repeat_i(repeat_i), .timeout_i(timeout_i), .start_o(start_o), .idle_i(idle_i),
        .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i), .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i), .dump_data_o(dump_data_o), .dump_node_o(dump_node_o),
        .dump_reg_o(dump_reg_o), .dump_iter_o(dump_iter_o), .dump_last_o(dump_last_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .run_cycles_o(run_cycles_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] pmu_val(input int n, input int a);
        return {16'hBEEF, 8'(n), 8'(a), 32'(n * 131 + a * 7 + 1)};
    endfunction

    always_comb begin
        for (int n = 0; n < 16; n++) pmu_data_i[n] = pmu_val(n, int'(pmu_addr_o));
    end

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  node;
        logic [4:0]  rg;
        logic [7:0]  iter;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] mask;
        logic [7:0]  reps;
        logic [31:0] tmo;
        int          delay;
        logic [15:0] stuck;
        int          rdy;
        logic [31:0] exp_cycles;
        logic        exp_tmo;
        int          exp_starts;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[7];
    int    n_checks = 0, n_fail = 0;
    int    cyc = 0, start_cyc = -1000, cur_delay = 0, rdy_mode = 0;
    int    n_starts = 0, n_dones = 0, n_valid_cyc = 0;
    logic [15:0] cur_mask = '0, cur_stuck = '0;
    logic  stalled = 1'b0, chk_stall = 1'b1;
    beat_t held;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One clock; sample DUT just after the edge, then drive the loader/sink models for this cycle.
    task automatic tick();
        beat_t got;
        @(posedge clk_i);
        #1;
        cyc++;
        if (start_o) begin
            start_cyc = cyc;
            n_starts++;
            idle_i = '0;
        end else if (cyc == start_cyc + cur_delay) begin
            idle_i = cur_mask & ~cur_stuck;
        end
        if (done_o) n_dones++;
        if (dump_valid_o) n_valid_cyc++;
        case (rdy_mode)
            0:       dump_ready_i = 1'b1;
            1:       dump_ready_i = ~dump_ready_i;
            default: dump_ready_i = 1'b0;
        endcase
        got = {dump_data_o, dump_node_o, dump_reg_o, dump_iter_o, dump_last_o};
        if (stalled && chk_stall) check("stall_hold", {dump_valid_o, 82'(got)}, {1'b1, 82'(held)});
        stalled = 1'b0;
        if (dump_valid_o) begin
            if (dump_ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got %0h required no beat", got);
                end else begin
                    check("beat", 96'(got), 96'(sb.pop_front()));
                end
            end else begin
                held    = got;
                stalled = 1'b1;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int    s0, d0, guard, iters, last_n;
        beat_t b;
        s0 = n_starts;
        d0 = n_dones;
        iters = v.exp_tmo ? 1 : ((v.reps == 0) ? 1 : int'(v.reps));
        last_n = -1;
        for (int n = 0; n < 16; n++) if (v.mask[n]) last_n = n;
        for (int it = 0; it < iters; it++)
            for (int n = 0; n < 16; n++)
                if (v.mask[n])
                    for (int r = 0; r < 8; r++) begin
                        b.data = pmu_val(n, r);
                        b.node = 4'(n);
                        b.rg   = 5'(r);
                        b.iter = 8'(it);
                        b.last = (n == last_n) && (r == 7);
                        sb.push_back(b);
                    end
        cur_mask = v.mask;
        cur_stuck = v.stuck;
        cur_delay = v.delay;
        rdy_mode = v.rdy;
        node_mask_i = v.mask;
        repeat_i = v.reps;
        timeout_i = v.tmo;
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        check("accept", {start_o, busy_o, timeout_o, done_o}, 4'b1100);
        guard = 0;
        while (n_dones == d0 && guard < 5000) begin
            tick();
            guard++;
        end
        check("done_seen", guard < 5000, 1'b1);
        check("run_cycles", run_cycles_o, v.exp_cycles);
        check("timeout_flag", timeout_o, v.exp_tmo);
        check("starts", n_starts - s0, v.exp_starts);
        check("sb_drained", sb.size(), 0);
        tick();
        check("end", {busy_o, done_o, 32'(n_dones - d0)}, {2'b00, 32'd1});
        sb.delete();
    endtask

    initial begin
        int s0, d0, v0, guard;
        //          mask      reps   tmo    dly stuck     rdy cycles tmo starts
        vecs[0] = '{16'hFFFF, 8'd1, 32'd0,  12, 16'h0000, 0, 32'd12, 1'b0, 1};
        vecs[1] = '{16'h0005, 8'd3, 32'd0,  6,  16'h0000, 1, 32'd6,  1'b0, 3};
        vecs[2] = '{16'h000F, 8'd4, 32'd20, 8,  16'h0008, 0, 32'd20, 1'b1, 1};
        vecs[3] = '{16'h8001, 8'd2, 32'd5,  5,  16'h0000, 1, 32'd5,  1'b0, 2};
        vecs[4] = '{16'h0100, 8'd0, 32'd0,  2,  16'h0000, 0, 32'd3,  1'b0, 1};
        vecs[5] = '{16'h0040, 8'd2, 32'd4,  9,  16'h0000, 0, 32'd4,  1'b1, 1};
        vecs[6] = '{16'h4210, 8'd2, 32'd0,  3,  16'h0000, 1, 32'd3,  1'b0, 2};

        rst_i = 1'b1; run_i = 1'b0; node_mask_i = '0; repeat_i = '0; timeout_i = '0;
        idle_i = '0; dump_ready_i = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", {start_o, busy_o, done_o, timeout_o, dump_valid_o, dump_last_o, run_cycles_o,
                             pmu_addr_o, dump_node_o, dump_reg_o, dump_iter_o}, '0);
        check("reset_data", dump_data_o, '0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Empty mask: straight to DONE, no start pulse, no beats.
        s0 = n_starts; v0 = n_valid_cyc;
        node_mask_i = '0; repeat_i = 8'd2; timeout_i = '0; run_i = 1'b1;
        tick();
        run_i = 1'b0;
        check("mask0_done", {done_o, busy_o, start_o}, 3'b110);
        tick();
        check("mask0_end", {done_o, busy_o, 32'(n_starts - s0), 32'(n_valid_cyc - v0)}, '0);

        // run_i held through the run, then reset while a beat is stalled.
        s0 = n_starts; d0 = n_dones;
        cur_mask = 16'h0003; cur_stuck = '0; cur_delay = 10; rdy_mode = 2;
        node_mask_i = 16'h0003; repeat_i = 8'd2; timeout_i = '0; run_i = 1'b1;
        tick();
        guard = 0;
        while (!dump_valid_o && guard < 200) begin
            tick();
            guard++;
        end
        check("scan_reached", dump_valid_o, 1'b1);
        tick();
        tick();
        check("no_restart", {busy_o, 32'(n_starts - s0)}, {1'b1, 32'd1});
        chk_stall = 1'b0;
        rst_i = 1'b1;
        run_i = 1'b0;
        tick();
        check("reset_abort", {start_o, busy_o, done_o, timeout_o, dump_valid_o, dump_last_o, run_cycles_o,
                              pmu_addr_o, dump_node_o, dump_reg_o, dump_iter_o}, '0);
        check("reset_abort_data", dump_data_o, '0);
        rst_i = 1'b0;
        s0 = n_starts; v0 = n_valid_cyc;
        repeat (30) tick();
        check("quiet_after_reset", {32'(n_dones - d0), 32'(n_starts - s0), 32'(n_valid_cyc - v0)}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
